// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: loader FSM states, default widths and the
// {real, imag} word packing used by the loader, butterfly and sample RAM.
package fft_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fft_state_e;

  // Real component occupies the upper half of the RAM word.
  function automatic logic [2*DATA_WIDTH_DEF-1:0] pack_sample(
    input logic [DATA_WIDTH_DEF-1:0] re,
    input logic [DATA_WIDTH_DEF-1:0] im
  );
    return {re, im};
  endfunction

endpackage

// File: rtl/fft_input_loader_bit_reverse.sv
// Combinational bit reversal of a sample index across ADDR_WIDTH bits.
module bit_reverse #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] value,
  output logic [ADDR_WIDTH-1:0] reversed
);

  for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
    assign reversed[i] = value[ADDR_WIDTH-1-i];
  end

endmodule

// File: rtl/fft_input_loader.sv
// Loads one frame of complex samples into the sample RAM, then runs the address
// generator and waits out its write-back drain. Define FFT_LOADER_BITREV_EN for
// bit-reversed write order; natural order otherwise.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_real,
  input  logic [DATA_WIDTH-1:0]   in_imag,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [2*DATA_WIDTH-1:0] mem_wdata,
  output logic                    fft_start,
  input  logic                    fft_done,
  output logic                    frame_done
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  fft_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     count_q, count_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_c;
  logic                      mem_we_d, fft_start_d, frame_done_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_d;
  logic [2*DATA_WIDTH-1:0]   mem_wdata_d;

`ifdef FFT_LOADER_BITREV_EN
  bit_reverse #(.ADDR_WIDTH(ADDR_WIDTH)) u_bit_reverse (
    .value    (count_q),
    .reversed (wr_addr_c)
  );
`else
  assign wr_addr_c = count_q;
`endif

  // Ready depends on state only, so there is no path from in_valid.
  assign in_ready = (state_q == LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      count_q    <= '0;
      drain_q    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      fft_start  <= fft_start_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    drain_d      = drain_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    fft_start_d  = fft_start;
    frame_done_d = 1'b0;

    case (state_q)
      LOAD: begin
        fft_start_d = 1'b0;
        if (in_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_c;
          mem_wdata_d = {in_real, in_imag};
          count_d     = count_q + ADDR_WIDTH'(1);
          if (count_q == LAST_IDX) begin
            state_d     = RUN;
            fft_start_d = 1'b1;
          end
        end
      end
      RUN: begin
        fft_start_d = 1'b1;
        if (fft_done) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        fft_start_d = 1'b1;
        if (drain_q == '0) begin
          state_d      = LOAD;
          fft_start_d  = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d     = LOAD;
        fft_start_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed-plus-random bench for fft_input_loader (N = 8, four drain cycles).
module tb_fft_input_loader;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned DC = 4;
  localparam int unsigned N  = 1 << AW;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_real;
  logic [DW-1:0]   in_imag;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [2*DW-1:0] mem_wdata;
  logic            fft_start;
  logic            fft_done;
  logic            frame_done;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  fft_input_loader #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .fft_start  (fft_start),
    .fft_done   (fft_done),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected RAM address of the idx-th sample of a frame.
  function automatic logic [AW-1:0] exp_addr(input int idx);
    logic [AW-1:0] r;
    r = AW'(idx);
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = idx[AW-1-b];
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_we"},     32'(mem_we),     32'd0);
    check({tag, " mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, " mem_wdata"},  mem_wdata,       32'd0);
    check({tag, " fft_start"},  32'(fft_start),  32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check({tag, " in_ready"},   32'(in_ready),   32'd1);
  endtask

  // One accepted sample: the write appears in the cycle after the edge.
  task automatic xfer(input logic [DW-1:0] re, input logic [DW-1:0] im, input int idx);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    check("ready before xfer", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_real  = DW'($urandom);
    in_imag  = DW'($urandom);
    check("mem_we", 32'(mem_we), 32'd1);
    check("mem_addr", 32'(mem_addr), 32'(exp_addr(idx)));
    check("mem_wdata", mem_wdata, {re, im});
    check("fft_start at write", 32'(fft_start), (idx == N - 1) ? 32'd1 : 32'd0);
  endtask

  task automatic idle_load();
    in_valid = 1'b0;
    tick();
    check("idle mem_we", 32'(mem_we), 32'd0);
    check("idle fft_start", 32'(fft_start), 32'd0);
  endtask

  // RUN for run_len cycles, pulse done, then expect DC cycles of drain.
  task automatic finish_frame(input int run_len, input bit hold_done);
    for (int k = 0; k < run_len; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      tick();
      check("run fft_start", 32'(fft_start), 32'd1);
      check("run in_ready", 32'(in_ready), 32'd0);
      check("run no write", 32'(mem_we), 32'd0);
      check("run frame_done", 32'(frame_done), 32'd0);
    end
    in_valid = 1'b0;
    fft_done = 1'b1;
    tick();
    fft_done = hold_done;
    check("drain fft_start", 32'(fft_start), 32'd1);
    for (int k = 1; k < DC; k++) begin
      tick();
      check("drain fft_start", 32'(fft_start), 32'd1);
      check("drain frame_done", 32'(frame_done), 32'd0);
    end
    tick();
    check("end fft_start", 32'(fft_start), 32'd0);
    check("end frame_done", 32'(frame_done), 32'd1);
    check("end in_ready", 32'(in_ready), 32'd1);
    fft_done = 1'b0;
    tick();
    check("after frame_done", 32'(frame_done), 32'd0);
    check("after fft_start", 32'(fft_start), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    fft_done = 1'b0;

    // Reset values, during and right after reset
    #2;
    check_reset_outputs("in reset");
    in_valid = 1'b1;
    tick();
    check_reset_outputs("reset edge");
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check_reset_outputs("post reset");

    // fft_done during LOAD is ignored
    fft_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ignored done start", 32'(fft_start), 32'd0);
      check("ignored done ready", 32'(in_ready), 32'd1);
    end
    fft_done = 1'b0;

    // Full frame, real=i, imag=-i, back-to-back
    for (int i = 0; i < N; i++) xfer(DW'(i), DW'(-i), i);
    finish_frame(10, 1'b0);

    // Throttled 1/0 input with random data; done held through drain
    for (int i = 0; i < N; i++) begin
      xfer(DW'($urandom), DW'($urandom), i);
      if (i < N - 1) idle_load();
    end
    finish_frame(int'($urandom_range(1, 15)), 1'b1);

    // Random gaps between samples
    for (int i = 0; i < N; i++) begin
      int gaps;
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) idle_load();
      xfer(DW'($urandom), DW'($urandom), i);
    end
    finish_frame(int'($urandom_range(0, 6)), 1'b0);

    // Reset mid-frame, then a complete new frame from index 0
    for (int i = 0; i < 5; i++) xfer(DW'($urandom), DW'($urandom), i);
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    tick();
    check_reset_outputs("held reset");
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check_reset_outputs("post mid reset");
    for (int i = 0; i < N; i++) xfer(DW'($urandom), DW'($urandom), i);
    finish_frame(int'($urandom_range(1, 8)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
